// File: rtl/trace_pkg.sv
// Shared types for the store trace monitor: trace record layout, FSM states
// and the "never finishes" program-counter value.
package trace_pkg;

    localparam int          STAMP_W   = 32;
    localparam logic [31:0] NO_FINISH = 32'hffff_ffff;

    typedef struct packed {
        logic [STAMP_W-1:0] cycle;
        logic [31:0]        addr;
        logic [31:0]        data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } mon_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records; pointers carry an extra wrap bit so
// full and empty can be told apart when the indices coincide.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  trace_entry_t push_entry,
    output logic         full,
    output logic         empty,
    output logic         last,
    output trace_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    trace_entry_t  r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_pop_ok;

    assign empty    = (r_wptr == r_rptr);
    assign full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign last     = ((r_wptr - r_rptr) == (AW+1)'(1));
    assign w_pop_ok = pop & ~empty;
    assign head     = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push)     r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop_ok) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage is not reset: a record is only visible once the pointers say so.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/store_trace_monitor.sv
// Watches the CPU data-memory write bus, time-stamps each store into a FIFO,
// streams records out over valid/ready and halts the CPU at the finish address.
module store_trace_monitor
    import trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc,
    input  logic [31:0]        pc_finished,
    input  logic               memwrite,
    input  logic [31:0]        aluout,
    input  logic [31:0]        writedata,
    output logic               halt,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [CYCLE_W-1:0] trace_cycle,
    output logic [31:0]        trace_addr,
    output logic [31:0]        trace_data,
    output logic               done,
    output logic               overflow,
    output logic [CNT_W-1:0]   store_count,
    output logic [CNT_W-1:0]   drop_count
);

    mon_state_t         r_state;
    mon_state_t         w_state_nxt;
    logic [CYCLE_W-1:0] r_cycle;
    logic [CNT_W-1:0]   r_store_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               r_ovf;
    logic               w_hit, w_capture, w_pop, w_push, w_drop;
    logic               w_full, w_empty, w_last;
    trace_entry_t       w_entry, w_head;

    assign w_hit     = (pc == pc_finished);
    assign halt      = w_hit | (r_state != RUN);
    assign w_capture = memwrite & ~halt;
    assign w_pop     = trace_valid & trace_ready;
    // A full FIFO still takes the store when the head leaves in the same cycle.
    assign w_push    = w_capture & (~w_full | w_pop);
    assign w_drop    = w_capture & w_full & ~w_pop;

    assign w_entry.cycle = STAMP_W'(r_cycle + CYCLE_W'(1));
    assign w_entry.addr  = aluout;
    assign w_entry.data  = writedata;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .pop        (w_pop),
        .push_entry (w_entry),
        .full       (w_full),
        .empty      (w_empty),
        .last       (w_last),
        .head       (w_head)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_hit) w_state_nxt = DRAIN;
            DRAIN:   if (w_empty || (w_pop && w_last)) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_cycle     <= '0;
            r_store_cnt <= '0;
            r_drop_cnt  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == RUN) r_cycle <= r_cycle + CYCLE_W'(1);
            if (w_push && (r_store_cnt != '1)) r_store_cnt <= r_store_cnt + CNT_W'(1);
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    // Record fields read as zero whenever nothing is buffered.
    assign trace_valid = ~w_empty;
    assign trace_cycle = trace_valid ? CYCLE_W'(w_head.cycle) : '0;
    assign trace_addr  = trace_valid ? w_head.addr : '0;
    assign trace_data  = trace_valid ? w_head.data : '0;
    assign done        = (r_state == DONE);
    assign overflow    = r_ovf;
    assign store_count = r_store_cnt;
    assign drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_store_trace_monitor.sv
// Randomized and directed bench for store_trace_monitor, checked every cycle
// against a queue-based reference model of the store trace.
module tb_store_trace_monitor;

    localparam int          DEPTH     = 16;
    localparam logic [31:0] NO_FIN_PC = 32'hffff_ffff;

    typedef struct {
        int unsigned cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, pc_finished, aluout, writedata;
    logic        memwrite, trace_ready;
    logic        halt, trace_valid, done, overflow;
    logic [31:0] trace_cycle, trace_addr, trace_data;
    logic [15:0] store_count, drop_count;

    store_trace_monitor #(.DEPTH(DEPTH), .CYCLE_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_finished (pc_finished),
        .memwrite    (memwrite),
        .aluout      (aluout),
        .writedata   (writedata),
        .halt        (halt),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_cycle (trace_cycle),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .done        (done),
        .overflow    (overflow),
        .store_count (store_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          dut_pops = 0;
    rec_t        q[$];
    int unsigned m_cyc;
    logic [15:0] m_store, m_drop;
    logic        m_ovf, m_fin, m_done;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cyc = 0; m_store = '0; m_drop = '0;
        m_ovf = 1'b0; m_fin = 1'b0; m_done = 1'b0;
    endtask

    // One clock edge of the reference: stores are numbered by the edge that takes them.
    task automatic model_step();
        bit   was_drain, hit, cap;
        rec_t r;
        was_drain = m_fin && !m_done;
        hit       = (pc == pc_finished);
        cap       = !m_fin && !hit && memwrite;
        if (!m_fin) m_cyc++;
        if (q.size() > 0 && trace_ready) void'(q.pop_front());
        if (cap) begin
            if (q.size() >= DEPTH) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hffff) m_drop++;
            end else begin
                r.cyc = m_cyc; r.addr = aluout; r.data = writedata;
                q.push_back(r);
                if (m_store != 16'hffff) m_store++;
            end
        end
        if (hit) m_fin = 1'b1;
        if (was_drain && q.size() == 0) m_done = 1'b1;
    endtask

    task automatic check_outputs();
        check_eq("valid", 64'(trace_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check_eq("cycle", 64'(trace_cycle), 64'(q[0].cyc));
            check_eq("addr", 64'(trace_addr), 64'(q[0].addr));
            check_eq("data", 64'(trace_data), 64'(q[0].data));
        end
        check_eq("done", 64'(done), 64'(m_done));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("store_count", 64'(store_count), 64'(m_store));
        check_eq("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    // Called at a negedge: drive inputs, check halt, take one edge, check outputs.
    task automatic tick(input logic [31:0] p, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy);
        pc = p; memwrite = we; aluout = a; writedata = d; trace_ready = rdy;
        #1;
        check_eq("halt", 64'(halt), 64'((pc == pc_finished) || m_fin));
        if (trace_valid && trace_ready) dut_pops++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input logic [31:0] fin);
        reset = 1'b0; pc_finished = fin; pc = '0; memwrite = 1'b0;
        aluout = '0; writedata = '0; trace_ready = 1'b0;
        #1;
        check_eq("rst_valid", 64'(trace_valid), 64'(0));
        check_eq("rst_cycle", 64'(trace_cycle), 64'(0));
        check_eq("rst_addr", 64'(trace_addr), 64'(0));
        check_eq("rst_data", 64'(trace_data), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_overflow", 64'(overflow), 64'(0));
        check_eq("rst_store", 64'(store_count), 64'(0));
        check_eq("rst_drop", 64'(drop_count), 64'(0));
        check_eq("rst_halt", 64'(halt), 64'(fin == 32'h0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic wait_done(input int bound, input bit rand_ready);
        int n;
        n = 0;
        while (!done && n < bound) begin
            tick(pc_finished, 1'($urandom_range(0, 1)), $urandom, $urandom,
                 rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        check_eq("done_reached", 64'(done), 64'(1));
    endtask

    initial begin
        rec_t        hold;
        logic [31:0] p;
        reset = 1'b0;
        @(negedge clk);

        // Two stores, finish at 0x40, then drain.
        do_reset(32'h40);
        tick(32'h0, 1'b0, '0, '0, 1'b1);
        tick(32'h4, 1'b0, '0, '0, 1'b1);
        tick(32'h8, 1'b1, 32'h54, 32'h7, 1'b1);
        check_eq("basic_rec1_cycle", 64'(trace_cycle), 64'(3));
        check_eq("basic_rec1_addr", 64'(trace_addr), 64'(32'h54));
        check_eq("basic_rec1_data", 64'(trace_data), 64'(32'h7));
        tick(32'hc, 1'b0, '0, '0, 1'b1);
        tick(32'h10, 1'b1, 32'h50, 32'h5, 1'b1);
        check_eq("basic_rec2_cycle", 64'(trace_cycle), 64'(5));
        check_eq("basic_rec2_addr", 64'(trace_addr), 64'(32'h50));
        check_eq("basic_rec2_data", 64'(trace_data), 64'(32'h5));
        tick(32'h40, 1'b0, '0, '0, 1'b1);
        check_eq("basic_not_done_yet", 64'(done), 64'(0));
        tick(32'h40, 1'b0, '0, '0, 1'b1);
        check_eq("basic_done", 64'(done), 64'(1));

        // Store in the same cycle the finish address appears.
        do_reset(32'h100);
        tick(32'h0, 1'b1, 32'h80, 32'h11, 1'b1);
        tick(32'h4, 1'b0, '0, '0, 1'b1);
        tick(32'h100, 1'b1, 32'h84, 32'h22, 1'b1);
        check_eq("coll_store_count", 64'(store_count), 64'(1));
        check_eq("coll_no_record", 64'(trace_valid), 64'(0));
        wait_done(10, 1'b0);

        // Backpressure: 18 stores into 16 entries.
        do_reset(NO_FIN_PC);
        for (int i = 0; i < 18; i++) tick(32'(4 * i), 1'b1, $urandom, $urandom, 1'b0);
        check_eq("bp_store_count", 64'(store_count), 64'(16));
        check_eq("bp_drop_count", 64'(drop_count), 64'(2));
        check_eq("bp_overflow", 64'(overflow), 64'(1));
        tick(32'h100, 1'b1, 32'hdead_0000, 32'hbeef, 1'b1);
        check_eq("full_pp_drop", 64'(drop_count), 64'(2));
        check_eq("full_pp_store", 64'(store_count), 64'(17));
        hold = q[0];
        for (int i = 0; i < 5; i++) begin
            tick(32'h104, 1'b0, '0, '0, 1'b0);
            check_eq("hold_cycle", 64'(trace_cycle), 64'(hold.cyc));
            check_eq("hold_addr", 64'(trace_addr), 64'(hold.addr));
            check_eq("hold_data", 64'(trace_data), 64'(hold.data));
        end
        dut_pops = 0;
        for (int i = 0; i < 20; i++) tick(32'h108, 1'b0, '0, '0, 1'b1);
        check_eq("full_pp_occupancy", 64'(dut_pops), 64'(16));

        // Random traffic, then finish with random backpressure.
        do_reset(32'h200);
        for (int i = 0; i < 400; i++) begin
            p = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            tick(p, 1'($urandom_range(0, 99) < 45), $urandom, $urandom,
                 1'($urandom_range(0, 99) < ((i < 200) ? 25 : 70)));
        end
        wait_done(200, 1'b1);

        // Asynchronous reset with records buffered.
        do_reset(NO_FIN_PC);
        for (int i = 0; i < 3; i++) tick(32'(4 * i), 1'b1, $urandom, $urandom, 1'b0);
        check_eq("mid_pre_valid", 64'(trace_valid), 64'(1));
        #2 reset = 1'b0;
        #1;
        check_eq("mid_valid_async", 64'(trace_valid), 64'(0));
        check_eq("mid_store", 64'(store_count), 64'(0));
        check_eq("mid_drop", 64'(drop_count), 64'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        tick(32'h0, 1'b1, 32'habc, 32'h123, 1'b0);
        check_eq("mid_first_stamp", 64'(trace_cycle), 64'(1));
        check_eq("mid_first_addr", 64'(trace_addr), 64'(32'habc));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, want finish before %0t", $time);
        $fatal(1);
    end

endmodule
